// File: rtl/sym_vn_lut_loader_if.sv
// Loader bus for the symmetric VN IB-LUT write path.
// Bundles the table-load control, the entry stream handshake and the
// sym_vn_rank write-port signals.
//   master : LUT update source / write-port consumer side
//   slave  : sym_vn_lut_loader side
interface sym_vn_lut_loader_if #(
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned PAGE_ADDR_W = 6
);
   logic                   load_start;
   logic                   load_offset;
   logic                   load_abort;
   logic [DATA_W-1:0]      entry_in;
   logic                   entry_valid;
   logic                   entry_ready;
   logic [DATA_W-1:0]      lut_in_bank0;
   logic [DATA_W-1:0]      lut_in_bank1;
   logic [PAGE_ADDR_W-1:0] page_write_addr;
   logic                   write_addr_offset;
   logic                   we;
   logic                   busy;
   logic                   load_done;

   modport master (
      output load_start, load_offset, load_abort, entry_in, entry_valid,
      input  entry_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
             write_addr_offset, we, busy, load_done
   );

   modport slave (
      input  load_start, load_offset, load_abort, entry_in, entry_valid,
      output entry_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
             write_addr_offset, we, busy, load_done
   );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// Write-side controller for the symmetric VN IB-LUT RAM rank.
// Packs a serial stream of LUT entries into bank0/bank1 pairs and issues
// one write per page into the selected half of the rank.
// Ports:
//   write_clk : write-domain clock, rising edge
//   rstn      : asynchronous active-low reset
//   bus       : slave side of sym_vn_lut_loader_if
//               (load_start/load_offset/load_abort control, entry_in/
//                entry_valid/entry_ready stream, lut_in_bank0/1,
//                page_write_addr, write_addr_offset, we write port,
//                busy/load_done status)
module sym_vn_lut_loader #(
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned PAGE_ADDR_W = 6,
   parameter int unsigned PAGE_NUM    = 64
) (
   input  logic                 write_clk,
   input  logic                 rstn,
   sym_vn_lut_loader_if.slave   bus
);

   localparam logic [PAGE_ADDR_W-1:0] LAST_PAGE = PAGE_ADDR_W'(PAGE_NUM - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_B0 = 2'd1,
      LOAD_B1 = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                 state;
   logic [PAGE_ADDR_W-1:0] page_cnt;
   logic [DATA_W-1:0]      bank0_hold;
   logic [DATA_W-1:0]      lut_in_bank0_q;
   logic [DATA_W-1:0]      lut_in_bank1_q;
   logic [PAGE_ADDR_W-1:0] page_write_addr_q;
   logic                   write_addr_offset_q;
   logic                   we_q;
   logic                   busy_q;
   logic                   load_done_q;
   logic                   entry_ready_c;
   logic                   handshake_c;

   // Ready is decoded straight from state so a stalled source sees it early.
   assign entry_ready_c = (state == LOAD_B0) || (state == LOAD_B1);
   assign handshake_c   = bus.entry_valid && entry_ready_c;

   // Load sequencer: abort wins over a coincident handshake.
   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         state               <= IDLE;
         page_cnt            <= '0;
         bank0_hold          <= '0;
         lut_in_bank0_q      <= '0;
         lut_in_bank1_q      <= '0;
         page_write_addr_q   <= '0;
         write_addr_offset_q <= 1'b0;
         we_q                <= 1'b0;
         busy_q              <= 1'b0;
         load_done_q         <= 1'b0;
      end else begin
         we_q        <= 1'b0;
         load_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load_start) begin
                  write_addr_offset_q <= bus.load_offset;
                  page_cnt            <= '0;
                  busy_q              <= 1'b1;
                  state               <= LOAD_B0;
               end
            end
            LOAD_B0: begin
               if (bus.load_abort) begin
                  page_cnt <= '0;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end else if (handshake_c) begin
                  bank0_hold <= bus.entry_in;
                  state      <= LOAD_B1;
               end
            end
            LOAD_B1: begin
               if (bus.load_abort) begin
                  page_cnt <= '0;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end else if (handshake_c) begin
                  lut_in_bank0_q    <= bank0_hold;
                  lut_in_bank1_q    <= bus.entry_in;
                  page_write_addr_q <= page_cnt;
                  we_q              <= 1'b1;
                  // Final page ends the load instead of wrapping the counter.
                  if (page_cnt == LAST_PAGE) begin
                     page_cnt <= '0;
                     state    <= DONE;
                  end else begin
                     page_cnt <= page_cnt + PAGE_ADDR_W'(1);
                     state    <= LOAD_B0;
                  end
               end
            end
            DONE: begin
               load_done_q <= 1'b1;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.entry_ready       = entry_ready_c;
   assign bus.lut_in_bank0      = lut_in_bank0_q;
   assign bus.lut_in_bank1      = lut_in_bank1_q;
   assign bus.page_write_addr   = page_write_addr_q;
   assign bus.write_addr_offset = write_addr_offset_q;
   assign bus.we                = we_q;
   assign bus.busy              = busy_q;
   assign bus.load_done         = load_done_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench for sym_vn_lut_loader.
module tb_sym_vn_lut_loader;

   localparam int unsigned DATA_W      = 4;
   localparam int unsigned PAGE_ADDR_W = 6;
   localparam int unsigned PAGE_NUM    = 64;
   localparam int          N_ENT       = 2 * PAGE_NUM;

   logic write_clk = 1'b0;
   logic rstn      = 1'b0;

   always #5 write_clk = ~write_clk;

   sym_vn_lut_loader_if #(.DATA_W(DATA_W), .PAGE_ADDR_W(PAGE_ADDR_W)) bus ();

   sym_vn_lut_loader #(
      .DATA_W(DATA_W), .PAGE_ADDR_W(PAGE_ADDR_W), .PAGE_NUM(PAGE_NUM)
   ) dut (
      .write_clk(write_clk),
      .rstn     (rstn),
      .bus      (bus)
   );

   typedef struct {
      int         cyc;
      logic [5:0] page;
      logic [3:0] b0;
      logic [3:0] b1;
      logic       off;
   } wr_t;

   int         cyc      = 0;
   int         checks   = 0;
   int         failures = 0;
   wr_t        wr_q[$];
   int         done_q[$];
   logic [3:0] data_q[$];
   int         hs_q[$];

   always @(posedge write_clk) cyc <= cyc + 1;

   // Observed write-port activity, sampled mid-cycle.
   always @(negedge write_clk) begin
      wr_t w;
      if (rstn) begin
         if (bus.we === 1'b1) begin
            w.cyc  = cyc;
            w.page = bus.page_write_addr;
            w.b0   = bus.lut_in_bank0;
            w.b1   = bus.lut_in_bank1;
            w.off  = bus.write_addr_offset;
            wr_q.push_back(w);
         end
         if (bus.load_done === 1'b1) done_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation did not terminate");
   end

   task automatic fill_data(input int n, input bit rnd);
      data_q.delete();
      for (int k = 0; k < n; k++) data_q.push_back(rnd ? 4'($urandom) : 4'(k % 16));
   endtask

   task automatic pulse_start(input logic off);
      @(negedge write_clk);
      bus.load_start  = 1'b1;
      bus.load_offset = off;
      @(posedge write_clk); #1;
      bus.load_start  = 1'b0;
   endtask

   // Streams data_q; every valid cycle of an active load is a handshake.
   task automatic drive_stream(input int pct, input int mid_idx);
      int   i = 0;
      logic v;
      hs_q.delete();
      while (i < data_q.size()) begin
         v = ($urandom_range(99) < 32'(pct));
         bus.load_start = 1'b0;
         if (i == mid_idx && v) begin
            bus.load_start  = 1'b1;
            bus.load_offset = 1'b0;
         end
         bus.entry_valid = v;
         bus.entry_in    = v ? data_q[i] : 4'($urandom);
         if (v) begin
            hs_q.push_back(cyc);
            i++;
         end
         @(posedge write_clk); #1;
      end
      bus.entry_valid = 1'b0;
      bus.load_start  = 1'b0;
   endtask

   task automatic test_reset();
      bus.load_start = 0; bus.load_offset = 0; bus.load_abort = 0;
      bus.entry_in = 0; bus.entry_valid = 0;
      rstn = 1'b0;
      #12;
      checks++; if (bus.entry_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.entry_ready); end
      checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.we); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.load_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.load_done); end
      checks++; if (bus.page_write_addr !== 6'd0) begin failures++; $display("FAIL reset_page got=%0d exp=0", bus.page_write_addr); end
      checks++; if (bus.write_addr_offset !== 1'b0) begin failures++; $display("FAIL reset_off got=%b exp=0", bus.write_addr_offset); end
      checks++; if (bus.lut_in_bank0 !== 4'd0 || bus.lut_in_bank1 !== 4'd0) begin
         failures++; $display("FAIL reset_banks got=%h/%h exp=0/0", bus.lut_in_bank0, bus.lut_in_bank1); end
      @(negedge write_clk);
      rstn = 1'b1;
   endtask

   // Full table load; expected page p = entries 2p/2p+1, write one cycle
   // after the bank1 handshake, load_done one cycle after the last write.
   task automatic test_table_load(input string tag, input logic off, input int pct,
                                  input int mid_idx, input bit rnd);
      fill_data(N_ENT, rnd);
      wr_q.delete(); done_q.delete();
      pulse_start(off);
      drive_stream(pct, mid_idx);
      repeat (4) @(posedge write_clk);
      @(negedge write_clk);
      checks++;
      if (wr_q.size() != PAGE_NUM) begin
         failures++; $display("FAIL %s_nwrites got=%0d exp=%0d", tag, wr_q.size(), PAGE_NUM);
      end
      for (int p = 0; p < PAGE_NUM && p < wr_q.size(); p++) begin
         checks++;
         if (wr_q[p].page !== 6'(p) || wr_q[p].b0 !== data_q[2*p] || wr_q[p].b1 !== data_q[2*p+1] ||
             wr_q[p].off !== off || wr_q[p].cyc != hs_q[2*p+1] + 1) begin
            failures++;
            $display("FAIL %s_write%0d got=pg%0d %h/%h off%b c%0d exp=pg%0d %h/%h off%b c%0d", tag, p,
                     wr_q[p].page, wr_q[p].b0, wr_q[p].b1, wr_q[p].off, wr_q[p].cyc,
                     p, data_q[2*p], data_q[2*p+1], off, hs_q[2*p+1] + 1);
         end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != hs_q[N_ENT-1] + 2) begin
         failures++;
         $display("FAIL %s_done got=n%0d c%0d exp=n1 c%0d", tag, done_q.size(),
                  (done_q.size() > 0) ? done_q[0] : -1, hs_q[N_ENT-1] + 2);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.entry_ready !== 1'b0) begin
         failures++; $display("FAIL %s_idle got=busy%b rdy%b exp=busy0 rdy0", tag, bus.busy, bus.entry_ready);
      end
   endtask

   task automatic test_abort();
      logic [3:0] last_b1;
      wr_q.delete(); done_q.delete();
      pulse_start(1'b1);
      fill_data(20, 1'b1);
      last_b1 = data_q[19];
      drive_stream(100, -1);
      // bank0 of page 10, then abort alongside the bank1 entry
      bus.entry_valid = 1'b1; bus.entry_in = 4'hA;
      @(posedge write_clk); #1;
      bus.entry_in = 4'h5; bus.load_abort = 1'b1;
      @(posedge write_clk); #1;
      bus.load_abort = 1'b0; bus.entry_valid = 1'b0;
      @(negedge write_clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.we !== 1'b0 || bus.entry_ready !== 1'b0) begin
         failures++; $display("FAIL abort_idle got=busy%b we%b rdy%b exp=000", bus.busy, bus.we, bus.entry_ready);
      end
      repeat (3) @(negedge write_clk);
      checks++;
      if (wr_q.size() != 10 || done_q.size() != 0) begin
         failures++; $display("FAIL abort_writes got=w%0d d%0d exp=w10 d0", wr_q.size(), done_q.size());
      end
      checks++;
      if (bus.page_write_addr !== 6'd9 || bus.lut_in_bank1 !== last_b1) begin
         failures++; $display("FAIL abort_hold got=pg%0d b1=%h exp=pg9 b1=%h", bus.page_write_addr, bus.lut_in_bank1, last_b1);
      end
      pulse_start(1'b0);
      fill_data(2, 1'b1);
      drive_stream(100, -1);
      repeat (2) @(negedge write_clk);
      checks++;
      if (wr_q.size() != 11 || wr_q[wr_q.size()-1].page !== 6'd0 || wr_q[wr_q.size()-1].off !== 1'b0 ||
          wr_q[wr_q.size()-1].b0 !== data_q[0] || wr_q[wr_q.size()-1].b1 !== data_q[1]) begin
         failures++;
         $display("FAIL abort_restart got=n%0d pg%0d off%b %h/%h exp=n11 pg0 off0 %h/%h", wr_q.size(),
                  wr_q[wr_q.size()-1].page, wr_q[wr_q.size()-1].off, wr_q[wr_q.size()-1].b0,
                  wr_q[wr_q.size()-1].b1, data_q[0], data_q[1]);
      end
      // abort while waiting for a bank0 entry
      @(negedge write_clk); bus.load_abort = 1'b1;
      @(negedge write_clk); bus.load_abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || done_q.size() != 0) begin
         failures++; $display("FAIL abort_b0 got=busy%b d%0d exp=busy0 d0", bus.busy, done_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      pulse_start(1'b1);
      fill_data(31, 1'b1);
      drive_stream(100, -1);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (bus.entry_ready !== 1'b0 || bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.load_done !== 1'b0 ||
          bus.page_write_addr !== 6'd0 || bus.write_addr_offset !== 1'b0 ||
          bus.lut_in_bank0 !== 4'd0 || bus.lut_in_bank1 !== 4'd0) begin
         failures++;
         $display("FAIL rst_mid got=rdy%b we%b busy%b done%b pg%0d off%b %h/%h exp=all zero",
                  bus.entry_ready, bus.we, bus.busy, bus.load_done, bus.page_write_addr,
                  bus.write_addr_offset, bus.lut_in_bank0, bus.lut_in_bank1);
      end
      @(negedge write_clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge write_clk);
         checks++;
         if (bus.entry_ready !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_idle%0d got=rdy%b busy%b exp=rdy0 busy0", i, bus.entry_ready, bus.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit found = 1'b0;
      wr_q.delete(); done_q.delete();
      fill_data(N_ENT, 1'b0);
      pulse_start(1'b0);
      drive_stream(100, -1);
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge write_clk);
         if (bus.load_done === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || wr_q.size() != PAGE_NUM) begin
         failures++; $display("FAIL b2b_first got=done%b n%0d exp=done1 n%0d", found, wr_q.size(), PAGE_NUM);
      end
      @(posedge write_clk); #1;
      bus.load_start = 1'b1; bus.load_offset = 1'b1;
      @(posedge write_clk); #1;
      bus.load_start = 1'b0;
      wr_q.delete(); done_q.delete();
      fill_data(N_ENT, 1'b1);
      drive_stream(100, -1);
      repeat (4) @(negedge write_clk);
      checks++;
      if (wr_q.size() != PAGE_NUM || done_q.size() != 1) begin
         failures++; $display("FAIL b2b_second got=n%0d d%0d exp=n%0d d1", wr_q.size(), done_q.size(), PAGE_NUM);
      end
      for (int p = 0; p < PAGE_NUM && p < wr_q.size(); p++) begin
         checks++;
         if (wr_q[p].page !== 6'(p) || wr_q[p].off !== 1'b1 ||
             wr_q[p].b0 !== data_q[2*p] || wr_q[p].b1 !== data_q[2*p+1]) begin
            failures++;
            $display("FAIL b2b_write%0d got=pg%0d off%b %h/%h exp=pg%0d off1 %h/%h", p, wr_q[p].page,
                     wr_q[p].off, wr_q[p].b0, wr_q[p].b1, p, data_q[2*p], data_q[2*p+1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_table_load("full", 1'b1, 100, -1, 1'b0);
      test_table_load("randvalid", 1'b1, 50, -1, 1'b0);
      test_table_load("midstart", 1'b1, 70, 40, 1'b1);
      test_abort();
      test_reset_mid_load();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sym_vn_lut_loader.md
Name: sym_vn_lut_loader

Overview:
- Write-side controller for the symmetric VN IB-LUT RAM rank; it is the write-port counterpart of the pipelined LUT read path.
- Accepts a serial stream of 4-bit IB-LUT entries over a valid/ready handshake and packs consecutive entries into bank0/bank1 pairs.
- Issues one write per page on page_write_addr/write_addr_offset/we/lut_in_bank0/lut_in_bank1, so a full table is loaded into the selected half of the rank.
- Sits between the LUT update source (host / density-evolution table feeder) and the sym_vn_rank write port.

Parameters:
- DATA_W, 4, width of one LUT entry and of each bank write word
- PAGE_ADDR_W, 6, page address width
- PAGE_NUM, 64, pages per table; last written page is PAGE_NUM-1

Ports:
- write_clk  input  1  write-domain clock, rising edge
- rstn  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse that starts a table load; honoured only in IDLE
- load_offset  input  1  table half to load; drives write_addr_offset for the whole load
- load_abort  input  1  aborts an in-progress load
- entry_in  input  DATA_W  LUT entry data
- entry_valid  input  1  entry_in valid
- entry_ready  output  1  loader accepts an entry this cycle
- lut_in_bank0  output  DATA_W  bank0 write data
- lut_in_bank1  output  DATA_W  bank1 write data
- page_write_addr  output  PAGE_ADDR_W  write page address
- write_addr_offset  output  1  write address offset (table half)
- we  output  1  write enable, one-cycle pulse per page
- busy  output  1  load in progress
- load_done  output  1  one-cycle pulse on completion of a full table

Behaviour:
- Reset (rstn low, asynchronous): state IDLE. All outputs 0: entry_ready, we, busy, load_done, page_write_addr, write_addr_offset, lut_in_bank0, lut_in_bank1. Internal page counter 0.
- States: IDLE, LOAD_B0, LOAD_B1, DONE. All outputs are registered except entry_ready, which is decoded from state.
- IDLE:
  - load_start=1: latch write_addr_offset<=load_offset, clear page counter, go to LOAD_B0, busy<=1.
  - Otherwise stay in IDLE.
- LOAD_B0:
  - entry_ready=1.
  - Handshake (entry_valid & entry_ready): entry captured into the bank0 holding register, go to LOAD_B1.
  - No valid entry: hold state.
- LOAD_B1:
  - entry_ready=1.
  - On handshake, next cycle: lut_in_bank0<=held bank0 entry, lut_in_bank1<=entry_in, page_write_addr<=page counter, we<=1 for exactly one cycle. Page counter increments.
  - If the page just written is PAGE_NUM-1, go to DONE; otherwise go to LOAD_B0.
- Entry mapping: stream index k (0..2*PAGE_NUM-1) goes to bank k[0], page k>>1.
- Throughput: sustained 1 entry/cycle, so one write every 2 cycles. Back-to-back we pulses are never adjacent.
- Write latency: we asserts 1 cycle after the handshake that completes the pair.
- lut_in_bank0/1 and page_write_addr hold their last values between writes.
- write_addr_offset is stable from the cycle after load_start until the next load_start.
- DONE: entry_ready=0; load_done=1 and busy=0 for one cycle, then IDLE. load_done rises the cycle after the final we.
- load_start outside IDLE is ignored and does not retarget the offset.
- load_abort=1 in LOAD_B0/LOAD_B1:
  - Next state IDLE, busy<=0, no we, no load_done.
  - A half-captured pair is discarded; the page counter clears.
  - Pages already written stay written.
- load_abort takes priority over a simultaneous handshake: that entry is dropped and no we is issued for it.
- load_abort in IDLE or DONE has no effect.
- rstn asserted mid-load behaves like abort, plus all outputs clear immediately.
- The page counter never wraps within a load; the final page ends the load.
- entry_in is ignored whenever entry_valid=0 or entry_ready=0.

Test Plan:
- Reset then load_start, load_offset=1, 128 entries streamed continuously with entry k = k mod 16 -> 64 we pulses every 2 cycles; page p writes bank0=(2p)%16, bank1=(2p+1)%16; write_addr_offset=1 throughout; load_done once, 1 cycle after the page-63 write; busy low afterwards.
- Same load with entry_valid toggled randomly (~50%) -> identical write sequence and contents; we only after bank1 handshakes; no write is lost or duplicated.
- load_start pulsed again mid-load with load_offset=0 -> ignored; write_addr_offset stays 1; load completes normally.
- load_abort asserted with a bank0 entry captured for page 10, simultaneous with entry_valid -> no we for page 10; busy=0 next cycle; no load_done; a new load_start restarts at page 0.
- rstn pulsed low asynchronously mid-cycle during LOAD_B1 -> all outputs 0 immediately; state IDLE; after release, entry_ready=0 until load_start.
- Two consecutive loads (offset 0 then 1) with load_start issued in the cycle after load_done -> second load accepted; page addresses restart at 0 with write_addr_offset=1.
